// File: rtl/data_mem_responder_if.sv
// data_mem_responder_if: request/response handshake bundle between core and data-memory responder.
// Latency: none, wires only.
// Backpressure: req_ready throttles requests, resp_ready holds completions.
interface data_mem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;

  // core side: issues requests, consumes completions
  modport master (
    output req_valid, req_write, req_addr, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  // memory side: accepts requests, produces completions
  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/data_mem_responder.sv
// data_mem_responder: single-outstanding load/store responder in front of a word-organised RAM.
// Latency: resp_valid rises WAIT_CYCLES+1 cycles after accept; at most one transaction per WAIT_CYCLES+2 cycles.
// Backpressure: req_ready is low while a request is in flight; the completion is held until resp_ready.
module data_mem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_CYCLES = 2
) (
  input logic                 clk,
  input logic                 rst,
  data_mem_responder_if.slave bus
);

  localparam int AW = $clog2(DEPTH_WORDS);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  logic [1:0]  state;
  logic [3:0]  wait_cnt;

  // request copy captured on accept; the bus inputs are don't-care afterwards
  logic        lat_write;
  logic [31:0] lat_addr;
  logic [31:0] lat_wdata;

  // completion registers, cleared on handshake and reset
  logic [31:0] rdata_q;
  logic        err_q;

  // word storage; contents survive reset
  logic [31:0] mem [DEPTH_WORDS];

  logic        accept;
  logic        commit;
  logic        c_write;
  logic [31:0] c_addr;
  logic [31:0] c_wdata;
  logic        c_err;
  logic [AW-1:0] c_idx;

  // Select the commit source: with no wait states the commit happens on the
  // accept edge itself, so it must use the live bus fields instead of the copy.
  always_comb begin
    accept  = (state == S_IDLE) && bus.req_valid;
    commit  = 1'b0;
    c_write = lat_write;
    c_addr  = lat_addr;
    c_wdata = lat_wdata;
    if (WAIT_CYCLES == 0) begin
      commit  = accept;
      c_write = bus.req_write;
      c_addr  = bus.req_addr;
      c_wdata = bus.req_wdata;
    end else begin
      commit  = (state == S_WAIT) && (wait_cnt == 4'd1);
    end
  end

  // Decode the committed address: misaligned or any word-index bit above the array is an error.
  always_comb begin
    c_idx = c_addr[AW+1:2];
    c_err = (c_addr[1:0] != 2'b00) || (|c_addr[31:AW+2]);
  end

  // Control FSM: accept in IDLE, count wait states in WAIT, hold the completion in RESP.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      wait_cnt  <= 4'd0;
      lat_write <= 1'b0;
      lat_addr  <= 32'd0;
      lat_wdata <= 32'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            lat_write <= bus.req_write;
            lat_addr  <= bus.req_addr;
            lat_wdata <= bus.req_wdata;
            wait_cnt  <= WAIT_INIT;
            state     <= (WAIT_CYCLES == 0) ? S_RESP : S_WAIT;
          end
        end
        S_WAIT: begin
          // counter is guarded against wrapping below zero
          if (wait_cnt != 4'd0) begin
            wait_cnt <= wait_cnt - 4'd1;
          end
          if (wait_cnt <= 4'd1) begin
            state <= S_RESP;
          end
        end
        S_RESP: begin
          if (bus.resp_ready) begin
            state <= S_IDLE;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // Completion data: loaded on commit, held through RESP, cleared on handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else if (commit) begin
      err_q   <= c_err;
      rdata_q <= (c_err || c_write) ? 32'd0 : mem[c_idx];
    end else if ((state == S_RESP) && bus.resp_ready) begin
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end
  end

  // Memory write for an error-free store; a reset on the commit edge drops the store.
  always_ff @(posedge clk) begin
    if (!rst && commit && c_write && !c_err) begin
      mem[c_idx] <= c_wdata;
    end
  end

  assign bus.req_ready  = (state == S_IDLE);
  assign bus.resp_valid = (state == S_RESP);
  assign bus.resp_rdata = rdata_q;
  assign bus.resp_err   = err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: bench for the data-memory responder, WAIT_CYCLES=2 and WAIT_CYCLES=0 instances.
// Latency: checks accept-to-response timing against WAIT_CYCLES+1.
// Backpressure: exercises held completions and held requests while busy.
module tb_data_mem_responder;

  localparam int DEPTH = 256;
  localparam int W     = 2;

  logic clk;
  logic rst;

  data_mem_responder_if bus ();
  data_mem_responder_if bus0 ();

  data_mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  data_mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0)) dut0 (
    .clk (clk),
    .rst (rst),
    .bus (bus0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // reference memory: word array indexed by byte address / 4
  logic [31:0] ref_mem [DEPTH];

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs [13];

  task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  // behavioural model of one transaction: error rule, load result, store effect
  function automatic void model_apply(input logic wr, input logic [31:0] addr,
                                      input logic [31:0] wdata,
                                      output logic [31:0] er, output logic ee);
    ee = ((addr % 4) != 0) || ((addr / 4) >= DEPTH);
    er = 32'd0;
    if (!ee) begin
      if (wr) ref_mem[addr / 4] = wdata;
      else    er = ref_mem[addr / 4];
    end
  endfunction

  // present a request at the current negedge and wait until it is taken
  task automatic accept(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic keep);
    int n;
    n = 0;
    bus.req_valid = 1'b1;
    bus.req_write = wr;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    while (bus.req_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk1("accept_ready", bus.req_ready, 1'b1);
    @(negedge clk);
    if (!keep) begin
      bus.req_valid = 1'b0;
      bus.req_write = 1'($urandom);
      bus.req_addr  = $urandom;
      bus.req_wdata = $urandom;
    end
  endtask

  // called in the cycle after accept; counts cycles until resp_valid
  task automatic wait_resp();
    int lat;
    lat = 1;
    while (bus.resp_valid !== 1'b1 && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    chk32("resp_latency", 32'(lat), 32'(W + 1));
  endtask

  // hold the completion for 'hold' cycles, then handshake and check the idle state after it
  task automatic finish_resp(input int hold);
    logic [31:0] r0;
    logic        e0;
    r0 = bus.resp_rdata;
    e0 = bus.resp_err;
    bus.resp_ready = 1'b0;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk1("hold_valid", bus.resp_valid, 1'b1);
      chk32("hold_rdata", bus.resp_rdata, r0);
      chk1("hold_err", bus.resp_err, e0);
      chk1("hold_req_ready", bus.req_ready, 1'b0);
    end
    bus.resp_ready = 1'b1;
    @(negedge clk);
    bus.resp_ready = 1'b0;
    chk1("post_req_ready", bus.req_ready, 1'b1);
    chk1("post_resp_valid", bus.resp_valid, 1'b0);
    chk32("post_rdata", bus.resp_rdata, 32'd0);
    chk1("post_err", bus.resp_err, 1'b0);
  endtask

  task automatic txn(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                     input int hold, output logic [31:0] rd, output logic er);
    accept(wr, addr, wdata, 1'b0);
    wait_resp();
    rd = bus.resp_rdata;
    er = bus.resp_err;
    finish_resp(hold);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd, er_m, a, d;
    logic        e, ee_m, wr;
    int          sel;

    vecs[0]  = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0};
    vecs[1]  = '{1'b0, 32'h0000_0010, 32'h0000_0000, 32'hDEAD_BEEF, 1'b0};
    vecs[2]  = '{1'b1, 32'h0000_0012, 32'h1111_1111, 32'h0000_0000, 1'b1};
    vecs[3]  = '{1'b0, 32'h0000_0010, 32'h0000_0000, 32'hDEAD_BEEF, 1'b0};
    vecs[4]  = '{1'b1, 32'h0000_0000, 32'h0123_4567, 32'h0000_0000, 1'b0};
    vecs[5]  = '{1'b0, 32'h0000_0400, 32'h0000_0000, 32'h0000_0000, 1'b1};
    vecs[6]  = '{1'b1, 32'h0000_0400, 32'h5555_5555, 32'h0000_0000, 1'b1};
    vecs[7]  = '{1'b0, 32'h0000_0000, 32'h0000_0000, 32'h0123_4567, 1'b0};
    vecs[8]  = '{1'b1, 32'h0000_03FC, 32'hA5A5_A5A5, 32'h0000_0000, 1'b0};
    vecs[9]  = '{1'b0, 32'h0000_03FC, 32'h0000_0000, 32'hA5A5_A5A5, 1'b0};
    vecs[10] = '{1'b0, 32'h0000_0013, 32'h0000_0000, 32'h0000_0000, 1'b1};
    vecs[11] = '{1'b0, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0000, 1'b1};
    vecs[12] = '{1'b1, 32'h0000_0020, 32'h1234_0000, 32'h0000_0000, 1'b0};

    bus.req_valid  = 1'b0;
    bus.req_write  = 1'b0;
    bus.req_addr   = 32'd0;
    bus.req_wdata  = 32'd0;
    bus.resp_ready = 1'b0;
    bus0.req_valid  = 1'b0;
    bus0.req_write  = 1'b0;
    bus0.req_addr   = 32'd0;
    bus0.req_wdata  = 32'd0;
    bus0.resp_ready = 1'b0;
    rst = 1'b1;

    // reset values
    @(negedge clk);
    @(negedge clk);
    chk1("rst_req_ready", bus.req_ready, 1'b1);
    chk1("rst_resp_valid", bus.resp_valid, 1'b0);
    chk32("rst_rdata", bus.resp_rdata, 32'd0);
    chk1("rst_err", bus.resp_err, 1'b0);
    rst = 1'b0;
    @(negedge clk);

    // directed vector table
    for (int i = 0; i < 13; i++) begin
      txn(vecs[i].wr, vecs[i].addr, vecs[i].wdata, i % 3, rd, e);
      model_apply(vecs[i].wr, vecs[i].addr, vecs[i].wdata, er_m, ee_m);
      chk32($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
      chk1($sformatf("vec%0d_err", i), e, vecs[i].exp_err);
    end

    // backpressure: completion held 5 cycles while a second request waits on the bus
    accept(1'b0, 32'h10, 32'd0, 1'b1);
    bus.req_write = 1'b0;
    bus.req_addr  = 32'h3FC;
    wait_resp();
    chk32("bp_rdata", bus.resp_rdata, 32'hDEAD_BEEF);
    chk1("bp_err", bus.resp_err, 1'b0);
    finish_resp(5);
    accept(1'b0, 32'h3FC, 32'd0, 1'b0);
    wait_resp();
    chk32("bp_held_rdata", bus.resp_rdata, 32'hA5A5_A5A5);
    finish_resp(0);

    // reset in the first wait cycle drops the store
    accept(1'b1, 32'h20, 32'hCAFE_F00D, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    chk1("midrst_req_ready", bus.req_ready, 1'b1);
    chk1("midrst_resp_valid", bus.resp_valid, 1'b0);
    chk32("midrst_rdata", bus.resp_rdata, 32'd0);
    chk1("midrst_err", bus.resp_err, 1'b0);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk1("midrst_quiet", bus.resp_valid, 1'b0);
    end
    txn(1'b0, 32'h20, 32'd0, 0, rd, e);
    chk32("midrst_old_word", rd, ref_mem[8]);

    // reset while the completion is pending keeps the committed store
    accept(1'b1, 32'h24, 32'h0000_0077, 1'b0);
    wait_resp();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk1("rresp_valid", bus.resp_valid, 1'b0);
    chk32("rresp_rdata", bus.resp_rdata, 32'd0);
    model_apply(1'b1, 32'h24, 32'h0000_0077, er_m, ee_m);
    txn(1'b0, 32'h24, 32'd0, 0, rd, e);
    chk32("rresp_kept_word", rd, 32'h0000_0077);

    // fill every word, then random traffic against the model
    for (int i = 0; i < DEPTH; i++) begin
      d = $urandom;
      txn(1'b1, 32'(i * 4), d, 0, rd, e);
      model_apply(1'b1, 32'(i * 4), d, er_m, ee_m);
      chk1("fill_err", e, ee_m);
    end
    for (int i = 0; i < 200; i++) begin
      sel = $urandom_range(0, 9);
      wr  = 1'($urandom);
      d   = $urandom;
      if (sel < 7)       a = 32'($urandom_range(0, DEPTH - 1) * 4);
      else if (sel == 7) a = 32'($urandom_range(0, DEPTH - 1) * 4 + $urandom_range(1, 3));
      else               a = $urandom | 32'h0000_0400;
      txn(wr, a, d, $urandom_range(0, 3), rd, e);
      model_apply(wr, a, d, er_m, ee_m);
      chk32("rand_rdata", rd, er_m);
      chk1("rand_err", e, ee_m);
    end

    // zero wait states: back-to-back stores then loads, resp_ready tied high
    bus0.resp_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      bus0.req_valid = 1'b1;
      bus0.req_write = (i < 8);
      bus0.req_addr  = 32'((i % 8) * 4);
      bus0.req_wdata = 32'hC0DE_0000 + 32'(i);
      chk1("w0_req_ready", bus0.req_ready, 1'b1);
      chk1("w0_idle_valid", bus0.resp_valid, 1'b0);
      @(negedge clk);
      chk1("w0_resp_valid", bus0.resp_valid, 1'b1);
      chk1("w0_busy_ready", bus0.req_ready, 1'b0);
      chk1("w0_err", bus0.resp_err, 1'b0);
      chk32("w0_rdata", bus0.resp_rdata, (i < 8) ? 32'd0 : 32'hC0DE_0000 + 32'(i - 8));
      @(negedge clk);
    end
    bus0.req_valid = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
